pwm_multi_channel: RTL
======================

PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameter NUM_CH, default 16: number of PWM output channels, range 1..32.
REQ-002 Parameter CNT_W, default 8: width of the period counter, duty and top values, range 4..16.
REQ-003 Parameter PRESC_W, default 8: width of the clock prescaler, range 1..16.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en_out  input  NUM_CH  per-channel output enable; 0 forces the channel low.
REQ-007 en_pwm  input  NUM_CH  per-channel PWM enable; 0 with en_out=1 forces the channel high.
REQ-008 duty  input  NUM_CH*CNT_W  packed duty values; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 top  input  CNT_W  period terminal count.
REQ-010 center  input  1  mode select: 0 = edge-aligned, 1 = center-aligned.
REQ-011 prescale  input  PRESC_W  counter advances once every prescale+1 clocks.
REQ-012 out  output  NUM_CH  registered PWM outputs.
REQ-013 period_start  output  1  registered one-cycle pulse marking a period boundary.

Function
REQ-014 The prescaler counter SHALL count 0..prescale and generate tick when it equals prescale, then return to 0; prescale=0 SHALL tick every clock.
REQ-015 The prescaler SHALL compare against the live prescale input, and any value at or below the current count SHALL tick on the next clock.
REQ-016 Shadow registers duty_sh, top_sh and center_sh SHALL load from the inputs only on a boundary tick; inputs changing mid-period SHALL have no effect until that tick.
REQ-017 Edge mode: on tick, cnt SHALL go to 0 if cnt == top_sh (boundary tick), else to cnt+1.
REQ-018 Center mode: cnt SHALL count up to top_sh and then down to 0, reversing direction at each end.
REQ-019 Center mode: the tick taking cnt from 1 to 0 is the boundary tick; top_sh=0 SHALL behave as edge mode.
REQ-020 On a boundary tick, cnt SHALL become 0 and the counting direction SHALL reset to up, regardless of any center_sh change.
REQ-021 period_start SHALL be 1 in the clock following each boundary tick and 0 otherwise.
REQ-022 Raw compare for channel i SHALL be 1 when cnt < duty_sh[i].
REQ-023 duty_sh[i] = all-ones SHALL force the raw compare to 1 (100%); duty_sh[i] = 0 SHALL force it to 0.
REQ-024 out[i] SHALL be registered as: 0 if en_out[i]=0, else 1 if en_pwm[i]=0, else the raw compare.
REQ-025 out[i] SHALL use the values of en_out, en_pwm, cnt and duty_sh from the previous clock, giving one clock of latency.
REQ-026 Edge-mode high time SHALL be duty ticks out of top+1; center-mode high time SHALL be 2*duty-1 ticks out of 2*top, symmetric about cnt=0.
REQ-027 Arithmetic SHALL be unsigned with no overflow; cnt never exceeds top_sh.
REQ-028 Channels SHALL share one counter and SHALL be mutually phase-aligned.

Reset
REQ-029 While rst_n=0 at a clock edge, the following SHALL be 0 on the next clock: prescaler, cnt, direction (up), duty_sh, top_sh, center_sh, out and period_start.
REQ-030 Because top_sh=0 after reset, the first tick after release SHALL be a boundary tick that loads the shadows.
REQ-031 Reset asserted mid-period SHALL abort the period immediately, with no partial pulse after release.

Verification
REQ-032 Edge duty: NUM_CH=16, CNT_W=8, top=255, prescale=0, duty[0]=128, en_out=en_pwm=1 -> out[0] high 128 of every 256 clocks, period_start every 256 clocks.
REQ-033 Static enables: en_out[3]=0 -> out[3]=0 constantly; en_out[4]=1 with en_pwm[4]=0 -> out[4]=1 constantly; duty 0xFF -> constant 1; duty 0 -> constant 0.
REQ-034 Shadowing: change duty[0] from 64 to 192 mid-period -> old 64-tick pulse completes, 192 takes effect exactly after the next period_start.
REQ-035 Center mode: top=10, duty=4, prescale=0 -> 20-clock period, 7-clock high pulse centered on cnt=0, edges symmetric.
REQ-036 Prescale: prescale=3, top=9 -> period_start every 40 clocks; then pulse rst_n low for 1 clock mid-period -> all outputs 0 next clock, and the first period_start occurs on the 4th clock after release.

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// PWM control/status bundle: per-channel enables, duty, period
// configuration in; registered PWM outputs and period marker out.
interface pwm_multi_channel_if #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
);
  logic [NUM_CH-1:0]       en_out;
  logic [NUM_CH-1:0]       en_pwm;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic [CNT_W-1:0]        top;
  logic                    center;
  logic [PRESC_W-1:0]      prescale;
  logic [NUM_CH-1:0]       out;
  logic                    period_start;

  modport master (
    output en_out, en_pwm, duty, top,
    output center, prescale,
    input  out, period_start
  );

  modport slave (
    input  en_out, en_pwm, duty, top,
    input  center, prescale,
    output out, period_start
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM sharing one prescaled counter; edge- or
// center-aligned, with duty/top/mode shadowed at period boundaries.
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  pwm_multi_channel_if.slave  bus
);

  logic [PRESC_W-1:0] r_psc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir_dn;
  logic [CNT_W-1:0]   r_duty_sh [NUM_CH];
  logic [CNT_W-1:0]   r_top_sh;
  logic               r_center_sh;
  logic [NUM_CH-1:0]  r_out;
  logic               r_ps;

  logic               w_tick;
  logic               w_center;
  logic               w_bound;
  logic [NUM_CH-1:0]  w_raw;

  // A prescale lowered below the running count ticks right away
  assign w_tick   = (r_psc >= bus.prescale);
  assign w_center = r_center_sh && (r_top_sh != '0);

  always_comb begin
    w_bound = 1'b0;
    if (w_tick) begin
      if (w_center)
        w_bound = (r_cnt == CNT_W'(1)) &&
                  (r_dir_dn || (r_cnt == r_top_sh));
      else
        w_bound = (r_cnt == r_top_sh);
    end
  end

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_raw[i] = (r_duty_sh[i] == '1) ||
                 (r_cnt < r_duty_sh[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc       <= '0;
      r_cnt       <= '0;
      r_dir_dn    <= 1'b0;
      r_top_sh    <= '0;
      r_center_sh <= 1'b0;
      r_out       <= '0;
      r_ps        <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        r_duty_sh[i] <= '0;
    end else begin
      r_psc <= w_tick ? '0 : r_psc + 1'b1;
      r_ps  <= w_bound;
      r_out <= bus.en_out & (~bus.en_pwm | w_raw);
      if (w_bound) begin
        r_cnt       <= '0;
        r_dir_dn    <= 1'b0;
        r_top_sh    <= bus.top;
        r_center_sh <= bus.center;
        for (int i = 0; i < NUM_CH; i++)
          r_duty_sh[i] <= bus.duty[i*CNT_W +: CNT_W];
      end else if (w_tick) begin
        if (!w_center) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (r_dir_dn) begin
          r_cnt <= r_cnt - 1'b1;
        end else if (r_cnt == r_top_sh) begin
          r_cnt    <= r_cnt - 1'b1;
          r_dir_dn <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out          = r_out;
  assign bus.period_start = r_ps;

endmodule
